block_serializer: RTL and testbench
===================================

// Module: block_serializer
// PURPOSE
//  Registers one wide block of N words (BUS_DATA_SIZE bits each) and emits its
//  words one per accepted beat on a narrow valid/ready bus, word 0 first.
//  Sits directly upstream of the mode logic's word datapath.
//  Word selection is done by an internal mux_gen instance driven by the beat index.
//  Words are treated as opaque bits; no share recombination takes place.
// PARAMETERS
//  N              8   words per block; N>=2, need not be a power of 2
//  BUS_DATA_SIZE  32  bits per word
//  log2N   $clog2(N)  derived width of the word index (do not override)
//  LENW  $clog2(N+1)  derived width of blk_len (do not override)
// PORTS
//  clk        in   1                  clock; all state updates on the rising edge
//  rst        in   1                  asynchronous reset, active-high
//  blk_in     in   N*BUS_DATA_SIZE    block; word i = blk_in[(i+1)*BUS_DATA_SIZE-1 : i*BUS_DATA_SIZE]
//  blk_len    in   LENW               number of words to emit (0..N; values >N clamp to N)
//  blk_valid  in   1                  block offered
//  blk_ready  out  1                  block accepted when blk_valid & blk_ready
//  data_out   out  BUS_DATA_SIZE      current word
//  data_valid out  1                  data_out is valid
//  data_ready in   1                  downstream accepts the beat when data_valid & data_ready
//  data_last  out  1                  current beat is the block's last word
//  busy       out  1                  high in SEND
// BEHAVIOUR
//  - Reset (asynchronous): state=IDLE, idx=0, len_r=0, blk_r=0.
//    data_valid=0, data_last=0, busy=0, blk_ready=1 (IDLE).
//  - FSM IDLE: blk_ready=1, data_valid=0.
//    On accept: blk_r<=blk_in, len_r<=min(blk_len,N), idx<=0.
//    Next state is SEND if len>0. If len==0, the block is consumed and no beats are emitted.
//  - FSM SEND: data_valid=1, data_out=word[idx] through mux_gen(ctrl=idx).
//    data_last = (idx==len_r-1).
//    On a beat with !data_last: idx<=idx+1.
//    On a beat with data_last: go to IDLE, or reload directly (see below).
//  - Latency: the first beat is valid in the cycle after block accept.
//    A block of L words completes in L cycles when data_ready=1.
//  - blk_ready = IDLE | (SEND & data_valid & data_ready & data_last).
//    A block offered during the final beat is accepted in that cycle and its
//    word 0 is valid on the next cycle, with zero bubble.
//  - Backpressure: while data_valid & !data_ready, data_out, data_last and idx are held stable.
//    No word is skipped or duplicated.
//  - Within a block, data_valid never drops without a completed beat.
//  - blk_in and blk_len are sampled only on accept; later changes are ignored.
//  - Reset mid-block: the block is discarded immediately and no data_last is emitted.
//    After release, the next block starts at word 0.
//  - idx never exceeds N-1; a non-power-of-2 N never selects an out-of-range word.
// STRUCTURE
//  - Shared package: IDLE/SEND state encoding localparams, and the clamp-to-N helper function.
//  - One sub-module: mux_gen #(N,BUS_DATA_SIZE), inputs blk_r and idx.
//  - Registers: state, idx[log2N], len_r[LENW], blk_r[N*BUS_DATA_SIZE].
//  - Outputs are derived from registered state only; there is no input-to-output
//    path except blk_ready from data_ready.
// TESTING
//  1. N=8,B=32, word i=32'h1111_1111*i, len=8, data_ready=1:
//     8 beats on consecutive cycles, words 0..7, data_last only on the beat carrying
//     32'h7777_7777, blk_ready=0 during beats 0..6.
//  2. Same block, data_ready pattern 1,0,0,1,0,1...:
//     data_out is stable during stalls, the received sequence is exactly 0..7, no duplicates.
//  3. Block B offered during A's last beat:
//     B accepted that cycle, B word 0 valid the next cycle, data_valid never drops.
//  4. Lengths:
//     len=3 gives words 0,1,2 with last on word 2.
//     len=0 is accepted, gives no beats, blk_ready stays 1.
//     len=15 is clamped, giving 8 beats.
//  5. rst pulsed after 3 beats of an 8-word block:
//     data_valid=0 asynchronously, no data_last.
//     A new block then starts at its word 0.
//  6. N=7,B=8, len=7, words 8'hA0..8'hA6:
//     beats A0..A6, last on A6, idx wraps to 0 for the next block.

Source files
------------

// File: rtl/block_serializer_pkg.sv
// Shared definitions for the block serializer: state encoding and the
// block-length clamp helper.
package block_serializer_pkg;

    localparam logic [0:0] IDLE_CODE = 1'b0;
    localparam logic [0:0] SEND_CODE = 1'b1;

    typedef enum logic [0:0] {
        ST_IDLE = IDLE_CODE,
        ST_SEND = SEND_CODE
    } state_e;

    function automatic int unsigned clamp_len(input int unsigned len, input int unsigned max_len);
        if (len > max_len) begin
            return max_len;
        end else begin
            return len;
        end
    endfunction

endpackage

// File: rtl/block_serializer_mux_gen.sv
// Word selector: picks word ctrl out of a packed block; an out-of-range
// select (possible when N is not a power of two) yields all zeros.
module mux_gen #(
    parameter int N             = 8,
    parameter int BUS_DATA_SIZE = 32,
    parameter int LOG2N         = $clog2(N)
) (
    input  logic [N*BUS_DATA_SIZE-1:0] blk,
    input  logic [LOG2N-1:0]           ctrl,
    output logic [BUS_DATA_SIZE-1:0]   word
);

    // AND-OR select across all words
    always_comb begin
        word = '0;
        for (int i = 0; i < N; i++) begin
            word = word | (blk[i*BUS_DATA_SIZE +: BUS_DATA_SIZE] & {BUS_DATA_SIZE{ctrl == LOG2N'(i)}});
        end
    end

endmodule

// File: rtl/block_serializer.sv
// Registers a block of N words and streams words 0..len-1 on a valid/ready
// bus; a new block can be taken during the final beat for back-to-back output.
module block_serializer
    import block_serializer_pkg::*;
#(
    parameter int N             = 8,
    parameter int BUS_DATA_SIZE = 32,
    parameter int LOG2N         = $clog2(N),
    parameter int LENW          = $clog2(N + 1)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N*BUS_DATA_SIZE-1:0] blk_in,
    input  logic [LENW-1:0]            blk_len,
    input  logic                       blk_valid,
    output logic                       blk_ready,
    output logic [BUS_DATA_SIZE-1:0]   data_out,
    output logic                       data_valid,
    input  logic                       data_ready,
    output logic                       data_last,
    output logic                       busy
);

    state_e                     state_r, state_nx_s;
    logic [LOG2N-1:0]           idx_r, idx_nx_s;
    logic [LENW-1:0]            len_r, len_nx_s, len_cl_s;
    logic [N*BUS_DATA_SIZE-1:0] blk_r, blk_nx_s;
    logic                       send_s, last_s, beat_s, accept_s;

    assign send_s     = (state_r == ST_SEND);
    assign last_s     = send_s && (LENW'(idx_r) == (len_r - LENW'(1)));
    assign beat_s     = send_s && data_ready;
    // Ready in IDLE, or during the final beat so the next block follows with no bubble
    assign blk_ready  = !send_s || (beat_s && last_s);
    assign accept_s   = blk_valid && blk_ready;
    assign len_cl_s   = LENW'(clamp_len(32'(blk_len), 32'(N)));

    assign data_valid = send_s;
    assign data_last  = last_s;
    assign busy       = send_s;

    mux_gen #(
        .N             (N),
        .BUS_DATA_SIZE (BUS_DATA_SIZE),
        .LOG2N         (LOG2N)
    ) u_mux (
        .blk  (blk_r),
        .ctrl (idx_r),
        .word (data_out)
    );

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
            idx_r   <= '0;
            len_r   <= '0;
            blk_r   <= '0;
        end else begin
            state_r <= state_nx_s;
            idx_r   <= idx_nx_s;
            len_r   <= len_nx_s;
            blk_r   <= blk_nx_s;
        end
    end

    // Next-state logic: load on accept, advance on non-final beats
    always_comb begin
        state_nx_s = state_r;
        idx_nx_s   = idx_r;
        len_nx_s   = len_r;
        blk_nx_s   = blk_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    blk_nx_s   = blk_in;
                    len_nx_s   = len_cl_s;
                    idx_nx_s   = '0;
                    state_nx_s = (len_cl_s != LENW'(0)) ? ST_SEND : ST_IDLE;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_SEND: begin
                if (accept_s) begin
                    blk_nx_s   = blk_in;
                    len_nx_s   = len_cl_s;
                    idx_nx_s   = '0;
                    state_nx_s = (len_cl_s != LENW'(0)) ? ST_SEND : ST_IDLE;
                end else if (beat_s && last_s) begin
                    idx_nx_s   = '0;
                    state_nx_s = ST_IDLE;
                end else if (beat_s) begin
                    idx_nx_s   = idx_r + LOG2N'(1);
                end else begin
                    idx_nx_s   = idx_r;
                end
            end
            default: begin
                idx_nx_s   = '0;
                state_nx_s = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_block_serializer.sv
// Self-checking bench: queue-based reference model compared every negedge,
// plus directed literal checks on the received word log.
module tb_block_serializer;

    localparam int N    = 8;
    localparam int B    = 32;
    localparam int LENW = 4;
    localparam int N2   = 7;
    localparam int B2   = 8;
    localparam int LENW2 = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [N*B-1:0]   blk_in;
    logic [LENW-1:0]  blk_len;
    logic             blk_valid, blk_ready, data_valid, data_ready, data_last, busy;
    logic [B-1:0]     data_out;

    logic [N2*B2-1:0] blk_in2;
    logic [LENW2-1:0] blk_len2;
    logic             blk_valid2, blk_ready2, data_valid2, data_ready2, data_last2, busy2;
    logic [B2-1:0]    data_out2;

    block_serializer #(.N(N), .BUS_DATA_SIZE(B)) dut (
        .clk(clk), .rst(rst), .blk_in(blk_in), .blk_len(blk_len), .blk_valid(blk_valid),
        .blk_ready(blk_ready), .data_out(data_out), .data_valid(data_valid),
        .data_ready(data_ready), .data_last(data_last), .busy(busy)
    );

    block_serializer #(.N(N2), .BUS_DATA_SIZE(B2)) dut2 (
        .clk(clk), .rst(rst), .blk_in(blk_in2), .blk_len(blk_len2), .blk_valid(blk_valid2),
        .blk_ready(blk_ready2), .data_out(data_out2), .data_valid(data_valid2),
        .data_ready(data_ready2), .data_last(data_last2), .busy(busy2)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    typedef struct {
        logic [31:0] w;
        logic        last;
    } beat_t;

    beat_t       q[$];
    logic [31:0] rx_w[$];
    logic        rx_last[$];
    int          rx_cyc[$];
    logic [7:0]  rx2_w[$];
    logic        rx2_last[$];

    logic        prev_stall = 1'b0;
    logic [31:0] prev_w;
    logic        prev_last;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: timed out (t=%0t)", name, $time);
    endtask

    // Reference: q holds exactly the words still owed for the current block
    task automatic model_clock();
        int  len;
        bit  beat;
        bit  rdy;
        beat = (q.size() > 0) && data_ready;
        rdy  = (q.size() == 0) || (beat && q.size() == 1);
        if (beat) void'(q.pop_front());
        if (blk_valid && rdy) begin
            len = (int'(blk_len) > N) ? N : int'(blk_len);
            for (int i = 0; i < len; i++)
                q.push_back('{w: blk_in[i*B +: B], last: (i == len - 1)});
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk or posedge rst) begin
        if (rst) q.delete();
        else     model_clock();
    end

    always @(negedge clk) begin
        if (rst) begin
            prev_stall <= 1'b0;
        end else begin
            check("data_valid", data_valid, q.size() > 0);
            check("busy", busy, q.size() > 0);
            check("blk_ready", blk_ready, (q.size() == 0) || (q.size() == 1 && data_ready));
            if (q.size() > 0) begin
                check("data_out", data_out, q[0].w);
                check("data_last", data_last, q[0].last);
            end else begin
                check("data_last_idle", data_last, 1'b0);
            end
            if (prev_stall) begin
                check("stall_hold_data", data_out, prev_w);
                check("stall_hold_last", data_last, prev_last);
            end
            if (data_valid && data_ready) begin
                rx_w.push_back(data_out);
                rx_last.push_back(data_last);
                rx_cyc.push_back(cyc);
            end
            if (data_valid2 && data_ready2) begin
                rx2_w.push_back(data_out2);
                rx2_last.push_back(data_last2);
            end
            prev_stall <= data_valid && !data_ready;
            prev_w     <= data_out;
            prev_last  <= data_last;
        end
    end

    function automatic logic [N*B-1:0] mk_blk(input logic [31:0] base, input logic [31:0] step);
        logic [N*B-1:0] r;
        for (int i = 0; i < N; i++) r[i*B +: B] = base + step * 32'(i);
        return r;
    endfunction

    // Offer a block to dut and return at posedge+1 after its accepting edge
    task automatic offer(input logic [N*B-1:0] blk, input int len);
        blk_in    = blk;
        blk_len   = LENW'(len);
        blk_valid = 1'b1;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (blk_ready) begin
                @(posedge clk);
                #1;
                blk_valid = 1'b0;
                blk_in    = {N{32'hDEAD_BEEF}};
                blk_len   = 4'd5;
                return;
            end
        end
        blk_valid = 1'b0;
        timeout_fail("offer");
    endtask

    task automatic offer2(input logic [N2*B2-1:0] blk, input int len);
        blk_in2    = blk;
        blk_len2   = LENW2'(len);
        blk_valid2 = 1'b1;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (blk_ready2) begin
                @(posedge clk);
                #1;
                blk_valid2 = 1'b0;
                blk_in2    = {N2{8'h5A}};
                return;
            end
        end
        blk_valid2 = 1'b0;
        timeout_fail("offer2");
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (!data_valid && !data_valid2) begin
                @(posedge clk);
                #1;
                return;
            end
        end
        timeout_fail("wait_idle");
    endtask

    task automatic check_seq(input string tag, input logic [31:0] base, input logic [31:0] step, input int n);
        check({tag, "_count"}, rx_w.size(), n);
        for (int i = 0; i < n && i < rx_w.size(); i++) begin
            check({tag, "_word"}, rx_w[i], base + step * 32'(i));
            check({tag, "_last"}, rx_last[i], (i == n - 1));
        end
    endtask

    task automatic clear_rx();
        rx_w.delete();
        rx_last.delete();
        rx_cyc.delete();
        rx2_w.delete();
        rx2_last.delete();
    endtask

    initial begin
        logic [5:0]       pat;
        logic [N2*B2-1:0] b2;
        bit               done;

        blk_in = '0;  blk_len = '0;  blk_valid = 1'b0;  data_ready = 1'b1;
        blk_in2 = '0; blk_len2 = '0; blk_valid2 = 1'b0; data_ready2 = 1'b1;

        #1;
        check("rst_blk_ready", blk_ready, 1'b1);
        check("rst_data_valid", data_valid, 1'b0);
        check("rst_data_last", data_last, 1'b0);
        check("rst_busy", busy, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // 1: full block, no backpressure
        clear_rx();
        offer(mk_blk(32'h0, 32'h1111_1111), 8);
        wait_idle();
        check_seq("t1", 32'h0, 32'h1111_1111, 8);
        if (rx_w.size() == 8) begin
            check("t1_word7", rx_w[7], 32'h7777_7777);
            check("t1_last7", rx_last[7], 1'b1);
            check("t1_last6", rx_last[6], 1'b0);
            check("t1_consecutive", rx_cyc[7] - rx_cyc[0], 7);
        end

        // 2: stall pattern 1,0,0,1,0,1 repeating
        clear_rx();
        offer(mk_blk(32'h0, 32'h1111_1111), 8);
        pat  = 6'b101001;
        done = 1'b0;
        for (int k = 0; k < 100 && !done; k++) begin
            data_ready = pat[k % 6];
            @(negedge clk);
            if (!data_valid) done = 1'b1;
            @(posedge clk);
            #1;
        end
        if (!done) timeout_fail("t2_drain");
        data_ready = 1'b1;
        check_seq("t2", 32'h0, 32'h1111_1111, 8);

        // 3: block B queued behind A's final beat
        clear_rx();
        offer(mk_blk(32'h0, 32'h1111_1111), 8);
        offer(mk_blk(32'hB000_0000, 32'h1), 4);
        wait_idle();
        check("t3_count", rx_w.size(), 12);
        if (rx_w.size() == 12) begin
            check("t3_b_word0", rx_w[8], 32'hB000_0000);
            check("t3_b_word3", rx_w[11], 32'hB000_0003);
            check("t3_a_last", rx_last[7], 1'b1);
            check("t3_b_last", rx_last[11], 1'b1);
            check("t3_b_mid", rx_last[10], 1'b0);
            check("t3_no_bubble", rx_cyc[11] - rx_cyc[0], 11);
        end

        // 4: lengths 3, 0, 15 (clamped)
        clear_rx();
        offer(mk_blk(32'h0, 32'h1111_1111), 3);
        wait_idle();
        check_seq("t4_len3", 32'h0, 32'h1111_1111, 3);
        clear_rx();
        offer(mk_blk(32'h0, 32'h1111_1111), 0);
        repeat (3) begin
            @(negedge clk);
            check("t4_len0_ready", blk_ready, 1'b1);
            check("t4_len0_valid", data_valid, 1'b0);
        end
        @(posedge clk);
        #1;
        check("t4_len0_count", rx_w.size(), 0);
        offer(mk_blk(32'h2000_0000, 32'h10), 15);
        wait_idle();
        check_seq("t4_len15", 32'h2000_0000, 32'h10, 8);

        // 5: reset after three beats
        clear_rx();
        offer(mk_blk(32'h0, 32'h1111_1111), 8);
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("t5_rst_valid", data_valid, 1'b0);
        check("t5_rst_last", data_last, 1'b0);
        check("t5_rst_busy", busy, 1'b0);
        check("t5_rst_ready", blk_ready, 1'b1);
        check("t5_beats_before", rx_w.size(), 3);
        for (int i = 0; i < rx_last.size(); i++) check("t5_no_last", rx_last[i], 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        clear_rx();
        offer(mk_blk(32'hC000_0000, 32'h1), 2);
        wait_idle();
        check_seq("t5_after", 32'hC000_0000, 32'h1, 2);

        // 6: N=7, 8-bit words
        clear_rx();
        for (int i = 0; i < N2; i++) b2[i*B2 +: B2] = 8'hA0 + 8'(i);
        offer2(b2, 7);
        wait_idle();
        check("t6_count", rx2_w.size(), 7);
        for (int i = 0; i < rx2_w.size(); i++) begin
            check("t6_word", rx2_w[i], 8'hA0 + 8'(i));
            check("t6_last", rx2_last[i], (i == 6));
        end
        clear_rx();
        for (int i = 0; i < N2; i++) b2[i*B2 +: B2] = 8'hB0 + 8'(i);
        offer2(b2, 3);
        wait_idle();
        check("t6_next_count", rx2_w.size(), 3);
        if (rx2_w.size() == 3) begin
            check("t6_next_word0", rx2_w[0], 8'hB0);
            check("t6_next_last", rx2_last[2], 1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
